// File: rtl/spi_slave_core.sv
// SPI slave with pin synchronizers, runtime CPOL/CPHA latched per selection,
// a single-entry TX buffer and an RX holding register with overrun/underrun flags.
module spi_slave_core #(
  parameter int DW   = 8,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpol,
  input  logic          cpha,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_load,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_avail,
  input  logic          rx_ack,
  output logic          rx_overrun,
  output logic          tx_underrun,
  output logic          busy,
  input  logic          spi_sclk,
  input  logic          spi_ss_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

  state_t          state_q, state_d;
  logic [SYNC-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC-1:0] ss_valid_q, ss_valid_d;
  logic            sclk_prev_q, sclk_prev_d;
  logic            ss_prev_q, ss_prev_d;
  logic            ss_armed_q, ss_armed_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   tx_buf_q, tx_buf_d;
  logic            tx_ready_q, tx_ready_d;
  logic            tx_underrun_q, tx_underrun_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rx_avail_q, rx_avail_d;
  logic            rx_overrun_q, rx_overrun_d;

  logic sclk_s, ss_s, mosi_s, ss_valid;
  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;

  assign sclk_s   = sclk_sync_q[SYNC-1];
  assign ss_s     = ss_sync_q[SYNC-1];
  assign mosi_s   = mosi_sync_q[SYNC-1];
  assign ss_valid = ss_valid_q[SYNC-1];

  assign lead_edge   = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
  assign trail_edge  = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  // A select is only honoured after ss_n has been seen high post-reset, so a
  // master still holding ss_n low across reset cannot restart a transfer.
  assign ss_fall     = ss_armed_q && ss_prev_q && !ss_s;

  always_comb begin
    state_d       = state_q;
    sclk_sync_d   = (sclk_sync_q << 1) | SYNC'(spi_sclk);
    ss_sync_d     = (ss_sync_q << 1) | SYNC'(spi_ss_n);
    mosi_sync_d   = (mosi_sync_q << 1) | SYNC'(spi_mosi);
    ss_valid_d    = (ss_valid_q << 1) | SYNC'(1'b1);
    sclk_prev_d   = sclk_s;
    ss_prev_d     = ss_s;
    ss_armed_d    = ss_armed_q | (ss_valid & ss_s);
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    tx_underrun_d = tx_underrun_q;
    rx_data_d     = rx_data_q;
    rx_avail_d    = rx_avail_q;
    rx_overrun_d  = rx_overrun_q;

    if (tx_load && tx_ready_q) begin
      tx_buf_d      = tx_data;
      tx_ready_d    = 1'b0;
      tx_underrun_d = 1'b0;
    end
    if (rx_ack) begin
      rx_avail_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!tx_ready_q) begin
          shift_d    = tx_buf_q;
          tx_ready_d = 1'b1;
        end else begin
          shift_d       = '1;
          tx_underrun_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        // A shift edge before the first sample belongs to the previous byte
        // (CPHA=0) or is the MSB-presenting edge (CPHA=1), so it is skipped.
        if (shift_edge && cnt_q != '0) begin
          shift_d = {shift_q[DW-2:0], bit_q};
        end
        if (sample_edge) begin
          bit_d = mosi_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            rx_data_d  = {shift_q[DW-2:0], mosi_s};
            rx_avail_d = 1'b1;
            if (rx_avail_q && !rx_ack) rx_overrun_d = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && ss_s) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sclk_sync_q   <= '0;
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      ss_valid_q    <= '0;
      sclk_prev_q   <= 1'b0;
      ss_prev_q     <= 1'b1;
      ss_armed_q    <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      shift_q       <= '0;
      bit_q         <= 1'b0;
      cnt_q         <= '0;
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      rx_data_q     <= '0;
      rx_avail_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_valid_q    <= ss_valid_d;
      sclk_prev_q   <= sclk_prev_d;
      ss_prev_q     <= ss_prev_d;
      ss_armed_q    <= ss_armed_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      cnt_q         <= cnt_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      rx_data_q     <= rx_data_d;
      rx_avail_q    <= rx_avail_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy & shift_q[DW-1];
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_avail    = rx_avail_q;
  assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI master at clk = 8x SCLK plus an
// RX scoreboard queue of the bytes the master sent.
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       reset, cpol, cpha, tx_load, rx_ack;
  logic       spi_sclk, spi_ss_n, spi_mosi;
  logic [7:0] tx_data, rx_data;
  logic       tx_ready, rx_avail, rx_overrun, tx_underrun, busy, spi_miso, spi_miso_oe;

  int         checks = 0;
  int         passes = 0;
  logic       m_cpol, m_cpha;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  spi_slave_core #(.DW(8), .SYNC(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
  endtask

  // Mode pins are scrambled once selected; the latched mode must be kept.
  task automatic select_slave(input logic pol, input logic pha);
    @(negedge clk);
    m_cpol = pol; m_cpha = pha; spi_sclk = pol; cpol = pol; cpha = pha;
    clks(4); spi_ss_n = 1'b0;
    clks(6); cpol = ~pol; cpha = ~pha;
    clks(2);
  endtask

  task automatic deselect();
    @(negedge clk); spi_ss_n = 1'b1;
    clks(8);
  endtask

  // Half SCLK period = 4 clk; optional rx_ack lands on the completion cycle.
  task automatic spi_bits(input logic [7:0] mo, input int n, input bit ack_last,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!m_cpha) begin
        spi_mosi = mo[7-i];
        clks(4);
        mi = {mi[6:0], spi_miso};
        spi_sclk = ~m_cpol;
        if (ack_last && i == n - 1) begin
          clks(2); rx_ack = 1'b1; clks(1); rx_ack = 1'b0; clks(1);
        end else begin
          clks(4);
        end
        spi_sclk = m_cpol;
      end else begin
        clks(4);
        spi_sclk = ~m_cpol;
        spi_mosi = mo[7-i];
        clks(4);
        mi = {mi[6:0], spi_miso};
        spi_sclk = m_cpol;
      end
    end
    clks(4);
  endtask

  task automatic test_reset();
    reset = 1'b1; cpol = 0; cpha = 0; tx_load = 0; rx_ack = 0; tx_data = 0;
    spi_sclk = 0; spi_ss_n = 1; spi_mosi = 0;
    clks(3); reset = 1'b0; clks(2);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (spi_miso_oe !== 1'b0) $display("[TB] FAIL reset_oe got %b want 0", spi_miso_oe); else passes++;
    checks++; if (spi_miso !== 1'b0) $display("[TB] FAIL reset_miso got %b want 0", spi_miso); else passes++;
    checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL reset_tx_ready got %b want 1", tx_ready); else passes++;
    checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data got %h want 00", rx_data); else passes++;
    checks++; if (rx_avail !== 1'b0) $display("[TB] FAIL reset_rx_avail got %b want 0", rx_avail); else passes++;
    checks++; if (rx_overrun !== 1'b0) $display("[TB] FAIL reset_overrun got %b want 0", rx_overrun); else passes++;
    checks++; if (tx_underrun !== 1'b0) $display("[TB] FAIL reset_underrun got %b want 0", tx_underrun); else passes++;
  endtask

  task automatic test_modes();
    logic [7:0] mi, exp;
    for (int m = 0; m < 4; m++) begin
      load_tx(8'hA5);
      select_slave(m[1], m[0]);
      checks++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1)
        $display("[TB] FAIL mode%0d_selected busy/oe got %b%b want 11", m, busy, spi_miso_oe); else passes++;
      rx_q.push_back(8'h3C);
      spi_bits(8'h3C, 8, 1'b0, mi);
      checks++; if (mi !== 8'hA5) $display("[TB] FAIL mode%0d_miso got %h want a5", m, mi); else passes++;
      exp = rx_q.pop_front();
      checks++; if (rx_data !== exp) $display("[TB] FAIL mode%0d_rx_data got %h want %h", m, rx_data, exp); else passes++;
      checks++; if (rx_avail !== 1'b1) $display("[TB] FAIL mode%0d_rx_avail got %b want 1", m, rx_avail); else passes++;
      checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL mode%0d_tx_ready got %b want 1", m, tx_ready); else passes++;
      deselect();
      checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0)
        $display("[TB] FAIL mode%0d_deselect busy/oe got %b%b want 00", m, busy, spi_miso_oe); else passes++;
      ack_rx();
      checks++; if (rx_avail !== 1'b0) $display("[TB] FAIL mode%0d_ack got %b want 0", m, rx_avail); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi, exp;
    load_tx(8'h5A);
    select_slave(1'b0, 1'b0);
    rx_q.push_back(8'h11);
    spi_bits(8'h11, 8, 1'b0, mi);
    checks++; if (mi !== 8'h5A) $display("[TB] FAIL b2b_miso1 got %h want 5a", mi); else passes++;
    exp = rx_q.pop_front();
    checks++; if (rx_data !== exp) $display("[TB] FAIL b2b_rx1 got %h want %h", rx_data, exp); else passes++;
    rx_q.push_back(8'h22);
    spi_bits(8'h22, 8, 1'b0, mi);
    checks++; if (mi !== 8'hFF) $display("[TB] FAIL b2b_miso2 got %h want ff", mi); else passes++;
    exp = rx_q.pop_front();
    checks++; if (rx_data !== exp) $display("[TB] FAIL b2b_rx2 got %h want %h", rx_data, exp); else passes++;
    checks++; if (tx_underrun !== 1'b1) $display("[TB] FAIL b2b_underrun got %b want 1", tx_underrun); else passes++;
    checks++; if (rx_overrun !== 1'b1) $display("[TB] FAIL b2b_overrun got %b want 1", rx_overrun); else passes++;
    deselect();
    ack_rx();
    checks++; if (rx_overrun !== 1'b0 || rx_avail !== 1'b0)
      $display("[TB] FAIL b2b_ack_clear ovr/avail got %b%b want 00", rx_overrun, rx_avail); else passes++;
    load_tx(8'h00);
    checks++; if (tx_underrun !== 1'b0 || tx_ready !== 1'b0)
      $display("[TB] FAIL b2b_load_clear und/rdy got %b%b want 00", tx_underrun, tx_ready); else passes++;
  endtask

  task automatic test_abort();
    logic [7:0] mi, exp;
    select_slave(1'b0, 1'b0);
    spi_bits(8'hF0, 5, 1'b0, mi);
    @(negedge clk); spi_ss_n = 1'b1;
    clks(3);
    checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0)
      $display("[TB] FAIL abort_idle busy/oe got %b%b want 00", busy, spi_miso_oe); else passes++;
    checks++; if (rx_avail !== 1'b0) $display("[TB] FAIL abort_rx_avail got %b want 0", rx_avail); else passes++;
    checks++; if (rx_data !== 8'h22) $display("[TB] FAIL abort_rx_data got %h want 22", rx_data); else passes++;
    clks(5);
    load_tx(8'hC3);
    select_slave(1'b0, 1'b0);
    rx_q.push_back(8'h96);
    spi_bits(8'h96, 8, 1'b0, mi);
    checks++; if (mi !== 8'hC3) $display("[TB] FAIL abort_next_miso got %h want c3", mi); else passes++;
    exp = rx_q.pop_front();
    checks++; if (rx_data !== exp) $display("[TB] FAIL abort_next_rx got %h want %h", rx_data, exp); else passes++;
    deselect();
  endtask

  task automatic test_ack_coincident();
    logic [7:0] mi, exp;
    checks++; if (rx_avail !== 1'b1) $display("[TB] FAIL ackc_pre_avail got %b want 1", rx_avail); else passes++;
    select_slave(1'b0, 1'b0);
    rx_q.push_back(8'hE7);
    spi_bits(8'hE7, 8, 1'b1, mi);
    checks++; if (mi !== 8'hFF) $display("[TB] FAIL ackc_miso got %h want ff", mi); else passes++;
    exp = rx_q.pop_front();
    checks++; if (rx_data !== exp) $display("[TB] FAIL ackc_rx_data got %h want %h", rx_data, exp); else passes++;
    checks++; if (rx_avail !== 1'b1) $display("[TB] FAIL ackc_avail got %b want 1", rx_avail); else passes++;
    checks++; if (rx_overrun !== 1'b0) $display("[TB] FAIL ackc_overrun got %b want 0", rx_overrun); else passes++;
    deselect();
    ack_rx();
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, exp;
    load_tx(8'h3F);
    select_slave(1'b1, 1'b1);
    spi_bits(8'hAA, 3, 1'b0, mi);
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0)
      $display("[TB] FAIL rstmid_pins busy/oe/miso got %b%b%b want 000", busy, spi_miso_oe, spi_miso); else passes++;
    checks++; if (tx_ready !== 1'b1 || tx_underrun !== 1'b0)
      $display("[TB] FAIL rstmid_tx rdy/und got %b%b want 10", tx_ready, tx_underrun); else passes++;
    checks++; if (rx_data !== 8'h00 || rx_avail !== 1'b0 || rx_overrun !== 1'b0)
      $display("[TB] FAIL rstmid_rx data/avail/ovr got %h/%b%b want 00/00", rx_data, rx_avail, rx_overrun); else passes++;
    clks(2); reset = 1'b0;
    spi_bits(8'hAA, 5, 1'b0, mi);
    checks++; if (busy !== 1'b0 || rx_avail !== 1'b0)
      $display("[TB] FAIL rstmid_no_resume busy/avail got %b%b want 00", busy, rx_avail); else passes++;
    deselect();
    load_tx(8'h81);
    select_slave(1'b0, 1'b0);
    rx_q.push_back(8'h7E);
    spi_bits(8'h7E, 8, 1'b0, mi);
    checks++; if (mi !== 8'h81) $display("[TB] FAIL rstmid_fresh_miso got %h want 81", mi); else passes++;
    exp = rx_q.pop_front();
    checks++; if (rx_data !== exp) $display("[TB] FAIL rstmid_fresh_rx got %h want %h", rx_data, exp); else passes++;
    deselect();
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_abort();
    test_ack_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter DW, default 8: bits per SPI frame (byte).
REQ-002 SHALL have parameter SYNC, default 2: flip-flop stages on each SPI pin input.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpol  input  1  SCLK idle level.
REQ-006 SHALL have port cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-007 SHALL have port tx_data  input  DW  next byte to return to the master.
REQ-008 SHALL have port tx_load  input  1  one-cycle write strobe for tx_data.
REQ-009 SHALL have port tx_ready  output  1  TX buffer empty.
REQ-010 SHALL have port rx_data  output  DW  last received byte.
REQ-011 SHALL have port rx_avail  output  1  unread byte held in rx_data.
REQ-012 SHALL have port rx_ack  input  1  one-cycle strobe that clears rx_avail and rx_overrun.
REQ-013 SHALL have port rx_overrun  output  1  sticky; byte completed while rx_avail=1.
REQ-014 SHALL have port tx_underrun  output  1  sticky; byte started with TX buffer empty; cleared by tx_load.
REQ-015 SHALL have port busy  output  1  slave selected (FSM not IDLE).
REQ-016 SHALL have port spi_sclk  input  1  asynchronous master clock.
REQ-017 SHALL have port spi_ss_n  input  1  asynchronous chip select, active-low.
REQ-018 SHALL have port spi_mosi  input  1  asynchronous master-out data.
REQ-019 SHALL have port spi_miso  output  1  slave-out data, MSB first.
REQ-020 SHALL have port spi_miso_oe  output  1  MISO tristate enable; high only while selected.

Function
REQ-021 SHALL pass spi_sclk, spi_ss_n and spi_mosi through SYNC flip-flops each, and detect SCLK edges on the synchronized signal only.
REQ-022 SHALL define the leading edge as SCLK moving cpol->~cpol and the trailing edge as the reverse.
REQ-023 SHALL require clk at least 8x the SCLK frequency; lower ratios are unsupported.
REQ-024 SHALL implement the FSM IDLE -> LOAD -> XFER -> (LOAD | IDLE).
REQ-025 IDLE: busy=0, spi_miso_oe=0, spi_miso=0; on a synchronized ss_n falling edge, latch cpol and cpha into mode registers and go to LOAD.
REQ-026 LOAD (one cycle): if the TX buffer is full, copy it to the shift register and set tx_ready=1; otherwise load all-ones and set tx_underrun; clear the bit counter; go to XFER.
REQ-027 XFER: spi_miso_oe=1 and spi_miso = shift register MSB; mosi is sampled into the shift LSB on the sampling edge; the shift register moves left on the shift edge.
REQ-028 cpha=0: sampling edge = leading, shift edge = trailing; MSB is valid on spi_miso in the cycle after LOAD.
REQ-029 cpha=1: shift edge = leading, and the first leading edge only presents the MSB (no shift); sampling edge = trailing.
REQ-030 On the DW-th sampling edge: in the next clk, rx_data <= received byte and rx_avail <= 1; set rx_overrun if rx_avail was already 1; then go to LOAD if ss_n is still low.
REQ-031 tx_load with tx_ready=1 SHALL write the TX buffer and clear tx_ready and tx_underrun; tx_load with tx_ready=0 SHALL be ignored.
REQ-032 tx_load in the same cycle as LOAD with the buffer empty: the current byte is sent as all-ones with tx_underrun set; the loaded byte is held for the next byte.
REQ-033 rx_ack in the same cycle as byte completion: rx_avail stays 1 with the new byte, and rx_overrun is not set.
REQ-034 Synchronized ss_n rising in any non-IDLE state SHALL abort: discard the partial byte, leave rx_* unchanged, go to IDLE next cycle, and deassert spi_miso_oe.
REQ-035 Changes on cpol or cpha while busy=1 SHALL have no effect until the next selection.
REQ-036 Latency: rx_avail asserts no more than SYNC+2 clk after the final sampling SCLK pin edge.

Reset
REQ-037 On reset: FSM=IDLE, shift register=0, bit counter=0, TX buffer=0, tx_ready=1, rx_data=0, rx_avail=0, rx_overrun=0, tx_underrun=0, busy=0, spi_miso=0, spi_miso_oe=0, synchronizers set to ss_n=1 and sclk=0.
REQ-038 Reset asserted mid-transfer SHALL force the reset state immediately; the slave SHALL not resume until a fresh ss_n falling edge.

Verification
REQ-039 Mode 0, clk=8x SCLK: load 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_avail=1; tx_ready=1.
REQ-040 Modes 1, 2 and 3: same exchange -> identical data in each mode, with sampling on the correct edge per REQ-028/029.
REQ-041 Two bytes under one ss_n, second tx_load never issued, no rx_ack -> second MISO byte 0xFF; tx_underrun=1; rx_overrun=1; rx_data = second byte.
REQ-042 ss_n deasserted after 5 bits -> rx_avail unchanged, busy=0 within SYNC+1 clk; the next full transfer is received correctly.
REQ-043 rx_ack coincident with byte completion -> rx_avail=1, rx_overrun=0; reset asserted mid-byte -> all outputs at REQ-037 values.
